// File: rtl/proj_fm_window_buf_if.sv
// Writer/reader bundle for the FM window buffer. The buffer takes the slave side; the
// producer/consumer pair (or a testbench) takes the master side.
interface proj_fm_window_buf_if #(
    parameter int DATA_BITS = 8,
    parameter int WIN       = 8,
    parameter int AW        = 8,
    parameter int LW        = 9,
    parameter int BW        = 1
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_BITS-1:0]     in_data;
    logic                     in_last;
    logic                     rd_avail;
    logic [LW-1:0]            rd_len;
    logic [BW-1:0]            rd_bank;
    logic                     rd_req;
    logic [AW-1:0]            rd_addr;
    logic [WIN*DATA_BITS-1:0] rd_data;
    logic                     rd_dvalid;
    logic                     rd_release;

    modport master (
        output in_valid, in_data, in_last, rd_req, rd_addr, rd_release,
        input  in_ready, rd_avail, rd_len, rd_bank, rd_data, rd_dvalid
    );

    modport slave (
        input  in_valid, in_data, in_last, rd_req, rd_addr, rd_release,
        output in_ready, rd_avail, rd_len, rd_bank, rd_data, rd_dvalid
    );
endinterface

// File: rtl/proj_fm_window_buf.sv
// N-bank circular genome byte buffer: the writer fills banks in turn, the reader pulls
// zero-padded WIN-byte windows from the oldest full bank and releases it when done.
module proj_fm_window_buf #(
    parameter  int BANKS     = 2,
    parameter  int DEPTH     = 256,
    parameter  int DATA_BITS = 8,
    parameter  int WIN       = 8,
    localparam int AW        = $clog2(DEPTH),
    localparam int LW        = $clog2(DEPTH + 1),
    localparam int BW        = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    proj_fm_window_buf_if.slave     bus
);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_e;

    bank_state_e              bank_state_q [BANKS];
    bank_state_e              bank_state_d [BANKS];
    logic [LW-1:0]            len_q        [BANKS];
    logic [LW-1:0]            len_d        [BANKS];
    logic [BW-1:0]            wptr_q, wptr_d;
    logic [BW-1:0]            rptr_q, rptr_d;
    logic [AW-1:0]            waddr_q, waddr_d;
    logic                     in_ready_q, in_ready_d;
    logic [WIN*DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic                     rd_dvalid_q, rd_dvalid_d;

    logic [DATA_BITS-1:0]     mem [BANKS][DEPTH];
    logic [AW:0]              win_addr [WIN];

    logic wr_fire, wr_close, rd_avail, rd_fire, rel_fire;

    function automatic logic [BW-1:0] bump(input logic [BW-1:0] p);
        return (p == BW'(BANKS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_fire  = bus.in_valid & in_ready_q;
    assign wr_close = wr_fire & (bus.in_last | (waddr_q == AW'(DEPTH - 1)));
    assign rd_avail = (bank_state_q[rptr_q] == BANK_FULL);
    assign rd_fire  = bus.rd_req & rd_avail;
    assign rel_fire = bus.rd_release & rd_avail;

    // Bank state machines and write/read pointers. Release touches only the open read
    // bank (FULL) and the writer only touches a non-FULL bank, so the two never collide.
    // NOTE: every combinational output gets its default first so no path infers a latch.
    always_comb begin
        bank_state_d = bank_state_q;
        len_d        = len_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        waddr_d      = waddr_q;

        if (rel_fire) begin
            bank_state_d[rptr_q] = BANK_EMPTY;
            rptr_d               = bump(rptr_q);
        end

        if (wr_fire) begin
            if (wr_close) begin
                bank_state_d[wptr_q] = BANK_FULL;
                len_d[wptr_q]        = LW'(waddr_q) + LW'(1);
                waddr_d              = '0;
                wptr_d               = bump(wptr_q);
            end else begin
                bank_state_d[wptr_q] = BANK_FILLING;
                waddr_d              = waddr_q + 1'b1;
            end
        end

        // Registered so a release never reaches in_ready combinationally.
        in_ready_d = (bank_state_d[wptr_d] != BANK_FULL);
    end

    always_comb begin
        for (int i = 0; i < WIN; i++) begin
            win_addr[i] = {1'b0, bus.rd_addr} + (AW + 1)'(i);
        end
    end

    // Window fetch from the open bank; bytes at or past the bank length read as zero,
    // which also keeps stale bytes from a previous fill out of the window.
    always_comb begin
        rd_data_d   = rd_data_q;
        rd_dvalid_d = rd_fire;
        if (rd_fire) begin
            for (int i = 0; i < WIN; i++) begin
                if (LW'(win_addr[i]) < len_q[rptr_q]) begin
                    rd_data_d[i*DATA_BITS +: DATA_BITS] = mem[rptr_q][win_addr[i][AW-1:0]];
                end else begin
                    rd_data_d[i*DATA_BITS +: DATA_BITS] = '0;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < BANKS; b++) begin
                bank_state_q[b] <= BANK_EMPTY;
                len_q[b]        <= '0;
            end
            wptr_q      <= '0;
            rptr_q      <= '0;
            waddr_q     <= '0;
            in_ready_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_dvalid_q <= 1'b0;
        end else begin
            bank_state_q <= bank_state_d;
            len_q        <= len_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            waddr_q      <= waddr_d;
            in_ready_q   <= in_ready_d;
            rd_data_q    <= rd_data_d;
            rd_dvalid_q  <= rd_dvalid_d;
        end
    end

    // NOTE: the byte store has no reset; the per-bank length gate hides whatever it holds.
    always_ff @(posedge clk) begin
        if (rst_n && wr_fire) begin
            mem[wptr_q][waddr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.rd_avail  = rd_avail;
    assign bus.rd_len    = rd_avail ? len_q[rptr_q] : '0;
    assign bus.rd_bank   = rptr_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_dvalid = rd_dvalid_q;

endmodule

// File: tb/tb_proj_fm_window_buf.sv
// Directed-plus-random bench for proj_fm_window_buf (BANKS=2, DEPTH=256, WIN=8 bytes).
// The reference keeps whole banks as byte arrays plus a FIFO of full banks in fill order.
module tb_proj_fm_window_buf;

    localparam int BANKS = 2;
    localparam int DEPTH = 256;
    localparam int DB    = 8;
    localparam int WIN   = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    proj_fm_window_buf_if #(.DATA_BITS(DB), .WIN(WIN), .AW(8), .LW(9), .BW(1)) bus ();

    proj_fm_window_buf #(.BANKS(BANKS), .DEPTH(DEPTH), .DATA_BITS(DB), .WIN(WIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bank contents, lengths, fill position and unread banks in order.
    logic [DB-1:0] mdl_mem [BANKS][DEPTH];
    int            mdl_len [BANKS];
    int            full_fifo [$];
    int            fill_bank;
    int            fill_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        full_fifo.delete();
        fill_bank = 0;
        fill_cnt  = 0;
    endtask

    task automatic model_write(input logic [DB-1:0] b, input bit last);
        mdl_mem[fill_bank][fill_cnt] = b;
        fill_cnt++;
        if (fill_cnt == DEPTH || last) begin
            mdl_len[fill_bank] = fill_cnt;
            full_fifo.push_back(fill_bank);
            fill_bank = (fill_bank + 1) % BANKS;
            fill_cnt  = 0;
        end
    endtask

    function automatic logic [63:0] exp_win(input int addr);
        logic [63:0] w;
        int          b;
        w = '0;
        b = full_fifo[0];
        for (int i = 0; i < WIN; i++) begin
            if (addr + i < mdl_len[b]) w[i*DB +: DB] = mdl_mem[b][addr + i];
        end
        return w;
    endfunction

    task automatic check_status();
        bit av;
        av = (full_fifo.size() > 0);
        check("in_ready", 64'(bus.in_ready), 64'(full_fifo.size() < BANKS));
        check("rd_avail", 64'(bus.rd_avail), 64'(av));
        if (av) begin
            check("rd_len",  64'(bus.rd_len),  64'(mdl_len[full_fifo[0]]));
            check("rd_bank", 64'(bus.rd_bank), 64'(full_fifo[0]));
        end
    endtask

    task automatic do_reset();
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.rd_req     = 1'b0;
        bus.rd_addr    = '0;
        bus.rd_release = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("in_ready_in_reset", 64'(bus.in_ready), 64'(0));
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),  64'(1));
        check("rst_rd_avail",  64'(bus.rd_avail),  64'(0));
        check("rst_rd_len",    64'(bus.rd_len),    64'(0));
        check("rst_rd_bank",   64'(bus.rd_bank),   64'(0));
        check("rst_rd_dvalid", 64'(bus.rd_dvalid), 64'(0));
        check("rst_rd_data",   bus.rd_data,        64'(0));
    endtask

    // One write attempt; starts and ends on a falling edge.
    task automatic push(input logic [DB-1:0] b, input bit last);
        bit exp_rdy;
        exp_rdy = (full_fifo.size() < BANKS);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = last;
        check("push_in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (exp_rdy) model_write(b, last);
    endtask

    task automatic read_win(input int addr, input bit rel, output logic [63:0] got);
        bit          av;
        logic [63:0] ew;
        av = (full_fifo.size() > 0);
        ew = '0;
        if (av) ew = exp_win(addr);
        bus.rd_req     = 1'b1;
        bus.rd_addr    = 8'(addr);
        bus.rd_release = rel;
        @(negedge clk);
        bus.rd_req     = 1'b0;
        bus.rd_release = 1'b0;
        got = bus.rd_data;
        check("rd_dvalid", 64'(bus.rd_dvalid), 64'(av));
        if (av) check("rd_data", bus.rd_data, ew);
        if (av && rel) void'(full_fifo.pop_front());
    endtask

    task automatic release_bank();
        bus.rd_release = 1'b1;
        @(negedge clk);
        bus.rd_release = 1'b0;
        if (full_fifo.size() > 0) void'(full_fifo.pop_front());
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("rd_dvalid_pulse", 64'(bus.rd_dvalid), 64'(0));
    endtask

    initial begin
        logic [63:0] w;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;

        // Reset state, then requests and releases with nothing open are ignored.
        do_reset();
        read_win(5, 1'b0, w);
        release_bank();
        check_status();

        // Full bank of 0..255: first window, end window with zero pad, back-to-back reads.
        for (int i = 0; i < DEPTH; i++) push(DB'(i), 1'b0);
        check_status();
        check("len_256", 64'(bus.rd_len), 64'(256));
        read_win(0, 1'b0, w);
        check("win_addr0", w, 64'h0706050403020100);
        read_win(252, 1'b0, w);
        check("win_addr252", w, 64'h00000000FFFEFDFC);
        for (int k = 0; k < 6; k++) read_win(int'($urandom_range(0, DEPTH - 1)), 1'b0, w);
        idle_check();
        release_bank();
        check_status();

        // Short bank of 5 bytes, then a bank closed on its very first byte.
        for (int i = 0; i < 5; i++) push(DB'(i), i == 4);
        check_status();
        check("len_5", 64'(bus.rd_len), 64'(5));
        read_win(2, 1'b0, w);
        check("win_short", w, 64'h0000000000040302);
        release_bank();
        push(DB'($urandom), 1'b1);
        check_status();
        read_win(0, 1'b0, w);
        read_win(255, 1'b0, w);
        release_bank();
        check_status();

        // Backpressure and ordering from a clean start.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(8'hAA, 1'b0);
        for (int i = 0; i < DEPTH; i++) push(8'hBB, 1'b0);
        check_status();
        push(8'h5A, 1'b0);
        push(8'h5B, 1'b0);
        read_win(int'($urandom_range(0, DEPTH - WIN)), 1'b0, w);
        check("win_bank0_aa", w, 64'hAAAAAAAAAAAAAAAA);
        release_bank();
        check_status();
        for (int i = 0; i < DEPTH; i++) push(DB'($urandom), 1'b0);
        check_status();
        read_win(int'($urandom_range(0, DEPTH - WIN)), 1'b1, w);
        check("win_bank1_bb", w, 64'hBBBBBBBBBBBBBBBB);
        check_status();
        for (int k = 0; k < 6; k++) read_win(int'($urandom_range(0, DEPTH - 1)), 1'b0, w);
        release_bank();
        check_status();

        // Reset in the middle of a fill discards it; the next fill starts at bank 0, addr 0.
        for (int i = 0; i < 100; i++) push(DB'($urandom), 1'b0);
        do_reset();
        check_status();
        for (int i = 0; i < DEPTH; i++) push(DB'($urandom), 1'b0);
        check_status();
        read_win(0, 1'b0, w);
        for (int k = 0; k < 6; k++) read_win(int'($urandom_range(0, DEPTH - 1)), 1'b0, w);
        read_win(DEPTH - 3, 1'b1, w);
        check_status();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
